// File: rtl/wb_ifetch_pkg.sv
// wb_ifetch_pkg
//   Shared types and constants for the J1 instruction prefetch path.
//   fetch_t pairs an instruction word with the word address it was fetched
//   from, at the default ROM geometry (8192 x 16).
package wb_ifetch_pkg;

  localparam int INSN_W     = 16;
  localparam int DEF_AWIDTH = 13;
  localparam int DEF_DEPTH  = 4;

  typedef struct packed {
    logic [INSN_W-1:0]     insn;
    logic [DEF_AWIDTH-1:0] pc;
  } fetch_t;

  // Width of the pending/discard counters. Two bits beyond the FIFO index
  // leave headroom for a flushed stream plus a full new credit window.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/wb_ifetch_fifo.sv
// sync_fifo
//   Small synchronous FIFO with flush, reusable by any Wishbone master.
//   Head data comes straight from registered storage, so a word is visible
//   the cycle after it is pushed.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          empties the FIFO; push and pop that cycle are ignored
//   push, wdata    write one entry (dropped if full and not popping)
//   pop            advance head (ignored when empty)
//   head           current head entry
//   count, empty   occupancy
module sync_fifo #(
  parameter int depth = 4,
  parameter int width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [width-1:0]       wdata,
  input  logic                   pop,
  output logic [width-1:0]       head,
  output logic [$clog2(depth):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(depth);
  localparam int FW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FW'(depth));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + FW'(1);
        2'b01:   count <= count - FW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_ifetch.sv
// wb_ifetch
//   Instruction prefetch unit for the J1 core. Acts as a pipelined Wishbone
//   master toward the instruction ROM, streams sequential 16-bit words into
//   a prefetch FIFO and presents them to the core with valid/ready. A
//   redirect flushes the FIFO, restarts at pc_in and drops acks that still
//   belong to the old stream.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wb_cyc, wb_stb     bus cycle / request strobe
//   wb_adr             word address of the request
//   wb_we, wb_dat_m    write enable and write data, both tied to zero
//   wb_dat_s           read data from the slave
//   wb_ack, wb_stall   slave acknowledge / pipeline stall
//   redirect, pc_in    load a new fetch address this cycle
//   insn_valid/ready   handshake to the core
//   insn, insn_pc      head instruction and its word address
module wb_ifetch
  import wb_ifetch_pkg::*;
#(
  parameter int          depth    = DEF_DEPTH,
  parameter int          awidth   = DEF_AWIDTH,
  parameter int unsigned reset_pc = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [awidth-1:0] wb_adr,
  output logic [15:0]       wb_dat_m,
  input  logic [15:0]       wb_dat_s,
  input  logic              wb_ack,
  input  logic              wb_stall,
  input  logic              redirect,
  input  logic [awidth-1:0] pc_in,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [15:0]       insn,
  output logic [awidth-1:0] insn_pc
);

  localparam int CW = cnt_width(depth);
  localparam int FW = $clog2(depth) + 1;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [awidth-1:0] pc;
  } entry_t;

  logic              rst_q;
  logic [awidth-1:0] adr;
  logic [awidth-1:0] ack_pc;
  logic [CW-1:0]     pending;
  logic [CW-1:0]     discard;
  logic [FW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              credit;
  logic              req_acc;
  logic              ack_new;
  logic              ack_old;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head_entry;

  // Requests in flight for the current stream plus words already buffered
  // never exceed depth, so every ack of the current stream has a FIFO slot.
  assign credit  = (CW'(fifo_count) + pending) < CW'(depth);
  assign wb_stb  = ~redirect & ~rst & ~rst_q & credit;
  assign wb_cyc  = ~rst & (wb_stb | (pending != '0) | (discard != '0));
  assign wb_adr  = adr;
  assign wb_we   = 1'b0;
  assign wb_dat_m = '0;

  assign req_acc = wb_stb & ~wb_stall;
  assign ack_old = wb_ack & (discard != '0);
  assign ack_new = wb_ack & (discard == '0);
  // An ack in the redirect cycle belongs to the old stream and is dropped.
  assign push    = ack_new & ~redirect;
  assign pop     = insn_valid & insn_ready & ~redirect;

  assign wr_entry = '{insn: wb_dat_s, pc: ack_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q   <= 1'b1;
      adr     <= awidth'(reset_pc);
      ack_pc  <= awidth'(reset_pc);
      pending <= '0;
      discard <= '0;
    end else begin
      rst_q <= 1'b0;
      if (redirect) begin
        adr     <= pc_in;
        ack_pc  <= pc_in;
        pending <= '0;
        // Everything still owed to the old stream moves into discard,
        // less the ack consumed at this edge, plus a request accepted now.
        discard <= discard + pending - CW'(wb_ack) + CW'(req_acc);
      end else begin
        if (req_acc) adr <= adr + awidth'(1);
        if (push)    ack_pc <= ack_pc + awidth'(1);
        if (ack_old) discard <= discard - CW'(1);
        pending <= pending + CW'(req_acc) - CW'(ack_new);
      end
    end
  end

  sync_fifo #(
    .depth (depth),
    .width ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .head  (head_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign insn_valid = ~fifo_empty;
  assign insn       = head_entry.insn;
  assign insn_pc    = head_entry.pc;

endmodule

// File: doc/wb_ifetch.md
# wb_ifetch

Instruction prefetch unit for the J1 core, sitting directly upstream of the Wishbone instruction ROM as its pipelined Wishbone master. It streams sequential 16-bit instruction words into a small prefetch FIFO and hands them to the core with a valid/ready handshake. On a core redirect (jump, call or return) it flushes the FIFO, restarts fetching at the new address, and discards any acks still in flight from the old stream.

## Interface
Parameters:
- depth, 4: prefetch FIFO entries; power of two, ≥2.
- awidth, 13: word-address width; matches ROM8192x16.
- reset_pc, 0: first fetch address after reset.

Ports (clock and reset arrive through the interface):
- wb.clk  in  1  clock; all logic on rising edge.
- wb.rst  in  1  synchronous, active-high reset.
- wb  if_wb.master  –  classic pipelined Wishbone master.
  - Drives cyc, stb, adr, we.
  - Samples dat_i, ack, stall.
  - we is tied to 0.
  - Write data is tied to 0: wb.dat_o, or wb.dat_m under NO_MODPORT_EXPRESSIONS.
- redirect  in  1  load new fetch address this cycle.
- pc_in  in  awidth  redirect target.
- insn_valid  out  1  FIFO head valid.
- insn_ready  in  1  core consumes head when valid & ready.
- insn  out  16  head instruction word.
- insn_pc  out  awidth  word address of head.

## Operation
- Request issue:
  - stb = ~redirect & ~rst_q & (fifo_count + pending < depth).
  - cyc = stb | (pending + discard != 0).
  - A request is accepted on stb & ~stall. adr then increments modulo 2^awidth.
  - adr is held while stall is high.
- Counters:
  - pending: accepted requests awaiting ack that belong to the current stream.
  - discard: acks still owed to a flushed stream.
  - Both counters are $clog2(depth)+2 bits wide.
- Ack handling:
  - ack with discard≠0 decrements discard; the data is dropped.
  - Otherwise ack decrements pending and pushes {dat_i, ack_pc} into the FIFO; ack_pc then increments.
- Redirect (highest priority):
  - Empties the FIFO and ignores any pop that cycle.
  - Loads adr and ack_pc with pc_in.
  - Sets discard = discard + pending + (ack accepted this edge ? −1 : 0) + (stb accepted this edge ? 1 : 0), and sets pending = 0.
  - An ack arriving in the redirect cycle always counts against the old stream.
- Pop: insn_valid & insn_ready advances the FIFO head.
  - Push and pop in the same cycle keep fifo_count unchanged.
  - The credit check guarantees the FIFO never overflows.
- Reset:
  - Outputs: cyc=0, stb=0, adr=reset_pc, insn_valid=0.
  - State: pending=0, discard=0, FIFO empty.
  - rst_q is a one-cycle delayed reset. The first stb goes high in the second cycle after rst deasserts.
  - Reset mid-burst abandons all in-flight requests. The slave's ack is also reset, so no stale ack arrives.

## Timing
- Zero-wait slave, redirect sampled at edge E0:
  - Cycle 1: stb=1, adr=pc_in.
  - Cycle 2: ack.
  - Cycle 3: insn_valid=1, insn=ROM[pc_in], insn_pc=pc_in.
  - Redirect-to-valid latency is 3 cycles.
- Steady state: one instruction per cycle while insn_ready=1. stb stays high continuously with depth≥2.
- n slave waitcycles add n cycles per word. Throughput becomes 1/(n+1).
- With the core stalled, exactly depth words are fetched (FIFO + pending), then stb drops.
- Outputs insn and insn_pc come straight from the FIFO head (registered storage, no bubbles).

## Structure
- Shared package j1_pkg: typedef fetch_t = struct packed {logic [15:0] insn; logic [awidth-1:0] pc}.
- Sub-module sync_fifo:
  - Parameterised depth and width.
  - Synchronous flush, push, pop.
  - Outputs count, empty, head data.
  - Reusable for other Wishbone masters.
- Top level holds the address and ack_pc counters, the pending/discard counters, and the request logic.

## Test plan
- Reset release, ROM waitcycles=0, ready=1:
  - First stb in cycle 2 after rst falls.
  - insn_valid two cycles later.
  - insn_pc sequence 0,1,2,… one per cycle, insn matching ROM.
- ready=0 from reset, depth=4:
  - Exactly 4 accepted requests, then stb=0 with cyc=0.
  - Raising ready drains 0..3, and fetching resumes at adr=4.
- Redirect to 0x100 in the cycle a request to 0x12 is accepted, waitcycles=2:
  - The 0x12 ack is discarded.
  - The first insn_pc is 0x100, and no old-stream word ever becomes valid.
- Redirect with simultaneous ack and pop:
  - FIFO empty next cycle.
  - discard=pending_old−1 (+1 if stb accepted).
  - Core sees no stale word.
- adr=0x1FFF, sequential run: next adr wraps to 0x000, and insn_pc follows 0x1FFF→0x000.
- rst asserted mid-burst with pending=3: next cycle cyc=0, insn_valid=0, and the counters are cleared.
